// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - multiplexed 3-digit seven-segment driver for a BCD result
//
// Captures a 3-digit BCD value on a load strobe. At each frame boundary the
// captured value moves into the display register, so a frame never tears.
// The driver scans one digit per refresh slot. Each slot starts with a guard
// band in which every digit is off, which prevents ghosting between digits.
// Leading-zero blanking is optional. A nibble above 9 is shown as a dash and
// raises err.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   bcd_in[11:0] {hundreds, tens, ones} BCD value
//   load         one-cycle strobe that captures bcd_in
//   blank_lz_en  leading-zero blanking enable (used live)
//   seg[6:0]     {g,f,e,d,c,b,a} segment drive
//   dp           decimal point, always inactive
//   dig_en[2:0]  one-hot digit enable: [0] ones, [1] tens, [2] hundreds
//   err          displayed value contains a non-decimal nibble
//   frame        one-cycle pulse when the scan wraps back to digit 0

module bcd_display_mux #(
    parameter int REFRESH_DIV = 27000,
    parameter int GUARD       = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  dig_en,
    output logic        err,
    output logic        frame
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GUARD_END = CW'(GUARD);
    localparam logic [6:0]     SEG_POL   = {7{ACTIVE_LOW}};
    localparam logic [2:0]     DIG_POL   = {3{ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   pend;
    logic          pend_v;
    logic [11:0]   disp;

    logic          tick;
    logic          wrap;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_hi;
    logic [2:0]    dig_hi;
    logic          err_nxt;

    // Active-high segment pattern for one BCD nibble; 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == 2'd2);

    // Prescaler, digit index and load staging.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 2'd0;
            pend   <= 12'h000;
            pend_v <= 1'b0;
            disp   <= 12'h000;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            // The display register only changes at the frame boundary. A load
            // that lands on the boundary itself bypasses the pending stage.
            if (wrap) begin
                if (load) begin
                    disp <= bcd_in;
                end else if (pend_v) begin
                    disp <= pend;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= bcd_in;
                pend_v <= 1'b1;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        blank  = 1'b0;
        seg_hi = 7'h00;
        dig_hi = 3'b000;

        case (idx)
            2'd0:    nib = disp[3:0];
            2'd1:    nib = disp[7:4];
            default: nib = disp[11:8];
        endcase

        // An invalid nibble is non-zero, so it stops the blanking run.
        if (blank_lz_en) begin
            case (idx)
                2'd2:    blank = (disp[11:8] == 4'h0);
                2'd1:    blank = (disp[11:8] == 4'h0) && (disp[7:4] == 4'h0);
                default: blank = 1'b0;
            endcase
        end

        if (cnt >= GUARD_END) begin
            case (idx)
                2'd0:    dig_hi = 3'b001;
                2'd1:    dig_hi = 3'b010;
                default: dig_hi = 3'b100;
            endcase
            seg_hi = blank ? 7'h00 : decode(nib);
        end

        err_nxt = (disp[3:0] > 4'd9) || (disp[7:4] > 4'd9) || (disp[11:8] > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg    <= SEG_POL;
            dig_en <= DIG_POL;
            err    <= 1'b0;
            frame  <= 1'b0;
        end else begin
            seg    <= seg_hi ^ SEG_POL;
            dig_en <= dig_hi ^ DIG_POL;
            err    <= err_nxt;
            frame  <= wrap;
        end
    end

    assign dp = ACTIVE_LOW;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - self-checking bench for bcd_display_mux
module tb_bcd_display_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        load = 1'b0;
    logic        blank_lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  dig_en;
    logic        err;
    logic        frame;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bcd_display_mux #(
        .REFRESH_DIV(8),
        .GUARD(2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bcd_in(bcd_in),
        .load(load),
        .blank_lz_en(blank_lz_en),
        .seg(seg),
        .dp(dp),
        .dig_en(dig_en),
        .err(err),
        .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic        blank;
        int          dig;
        logic [2:0]  exp_dig;
        logic [6:0]  exp_seg;
        logic        exp_err;
    } vec_t;

    vec_t tbl[26];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        if (k < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL run_to: cycle %0d already passed, now %0d", k, cyc);
        end
        while (cyc < k) step();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    task automatic load_at(input int k, input logic [11:0] val);
        run_to(k - 1);
        bcd_in = val;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [2:0] exp_dig, input logic [6:0] exp_seg);
        vectors++;
        if ({dp, dig_en, seg} !== {1'b1, exp_dig, exp_seg}) begin
            miscompares++;
            $display("FAIL %s @%0d: dp/dig_en/seg got %b/%b/%h expected 1/%b/%h",
                     name, cyc, dp, dig_en, seg, exp_dig, exp_seg);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic show(input string name, input int k, input logic [2:0] d, input logic [6:0] s);
        run_to(k);
        check_state(name, d, s);
    endtask

    initial begin
        tbl[0]  = '{12'h123, 1'b0, 0, 3'b110, 7'h30, 1'b0};
        tbl[1]  = '{12'h123, 1'b0, 1, 3'b101, 7'h24, 1'b0};
        tbl[2]  = '{12'h123, 1'b0, 2, 3'b011, 7'h79, 1'b0};
        tbl[3]  = '{12'h007, 1'b1, 0, 3'b110, 7'h78, 1'b0};
        tbl[4]  = '{12'h007, 1'b1, 1, 3'b101, 7'h7F, 1'b0};
        tbl[5]  = '{12'h007, 1'b1, 2, 3'b011, 7'h7F, 1'b0};
        tbl[6]  = '{12'h007, 1'b0, 1, 3'b101, 7'h40, 1'b0};
        tbl[7]  = '{12'h007, 1'b0, 2, 3'b011, 7'h40, 1'b0};
        tbl[8]  = '{12'h070, 1'b1, 1, 3'b101, 7'h78, 1'b0};
        tbl[9]  = '{12'h070, 1'b1, 0, 3'b110, 7'h40, 1'b0};
        tbl[10] = '{12'h070, 1'b1, 2, 3'b011, 7'h7F, 1'b0};
        tbl[11] = '{12'h1A3, 1'b0, 1, 3'b101, 7'h3F, 1'b1};
        tbl[12] = '{12'h1A3, 1'b0, 0, 3'b110, 7'h30, 1'b1};
        tbl[13] = '{12'h0A0, 1'b1, 2, 3'b011, 7'h7F, 1'b1};
        tbl[14] = '{12'h0A0, 1'b1, 1, 3'b101, 7'h3F, 1'b1};
        tbl[15] = '{12'h0A0, 1'b1, 0, 3'b110, 7'h40, 1'b1};
        tbl[16] = '{12'h999, 1'b0, 2, 3'b011, 7'h10, 1'b0};
        tbl[17] = '{12'h845, 1'b0, 2, 3'b011, 7'h00, 1'b0};
        tbl[18] = '{12'h845, 1'b0, 1, 3'b101, 7'h19, 1'b0};
        tbl[19] = '{12'h845, 1'b0, 0, 3'b110, 7'h12, 1'b0};
        tbl[20] = '{12'h006, 1'b1, 0, 3'b110, 7'h02, 1'b0};
        tbl[21] = '{12'h00F, 1'b1, 0, 3'b110, 7'h3F, 1'b1};
        tbl[22] = '{12'h00F, 1'b1, 1, 3'b101, 7'h7F, 1'b1};
        tbl[23] = '{12'h000, 1'b1, 0, 3'b110, 7'h40, 1'b0};
        tbl[24] = '{12'hF00, 1'b1, 2, 3'b011, 7'h3F, 1'b1};
        tbl[25] = '{12'hF00, 1'b1, 1, 3'b101, 7'h40, 1'b1};

        // Reset mid-slot with err set and a load pending; the pending value
        // must never appear afterwards.
        reset_dut();
        load_at(0, 12'h1A3);
        load_at(30, 12'h456);
        run_to(33);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("reset_out", 3'b111, 7'h7F);
            check_bit("reset_err", err, 1'b0);
            check_bit("reset_frame", frame, 1'b0);
        end
        rst_n = 1'b1;
        cyc = -1;
        for (int k = 0; k < 72; k++) begin
            logic [2:0] ed;
            logic [6:0] es;
            step();
            ed = 3'b111;
            es = 7'h7F;
            if ((k % 8) >= 2) begin
                ed[(k / 8) % 3] = 1'b0;
                es = 7'h40;
            end
            check_state("scan", ed, es);
            check_bit("frame", frame, (k % 24) == 23);
            check_bit("scan_err", err, 1'b0);
        end

        // err follows the displayed value, one cycle after it changes.
        reset_dut();
        load_at(0, 12'h1A3);
        run_to(23);
        check_bit("err_before", err, 1'b0);
        run_to(24);
        check_bit("err_set", err, 1'b1);
        load_at(30, 12'h123);
        run_to(47);
        check_bit("err_hold", err, 1'b1);
        run_to(48);
        check_bit("err_clear", err, 1'b0);

        // Load mid-frame: current frame keeps the old value.
        reset_dut();
        load_at(0, 12'h123);
        load_at(35, 12'h456);
        show("mid_old_tens", 36, 3'b101, 7'h24);
        show("mid_old_hund", 44, 3'b011, 7'h79);
        show("mid_new_ones", 52, 3'b110, 7'h02);
        show("mid_new_tens", 60, 3'b101, 7'h12);
        show("mid_new_hund", 68, 3'b011, 7'h19);

        // Two loads in one frame: last wins.
        reset_dut();
        load_at(0, 12'h111);
        load_at(10, 12'h222);
        show("two_ones", 28, 3'b110, 7'h24);
        load_at(30, 12'h333);
        load_at(40, 12'h444);
        show("two_hund_old", 44, 3'b011, 7'h24);
        show("two_ones_new", 52, 3'b110, 7'h19);
        show("two_hund_new", 68, 3'b011, 7'h19);

        // Load on the wrap tick goes straight to the display.
        reset_dut();
        load_at(0, 12'h123);
        show("wrap_before", 44, 3'b011, 7'h79);
        load_at(47, 12'h789);
        show("wrap_ones", 52, 3'b110, 7'h10);
        show("wrap_hund", 68, 3'b011, 7'h78);
        show("wrap_next", 76, 3'b110, 7'h10);

        // Decode and blanking table.
        for (int i = 0; i < 26; i++) begin
            reset_dut();
            blank_lz_en = tbl[i].blank;
            load_at(0, tbl[i].bcd);
            run_to(24 + 8 * tbl[i].dig + 4);
            check_state($sformatf("vec%0d", i), tbl[i].exp_dig, tbl[i].exp_seg);
            check_bit($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Consumer of the ALU's 12-bit, 3-digit BCD result; drives a multiplexed common-anode 3-digit seven-segment display on the Gowin board.
- Captures a result on a load strobe and scans one digit per refresh slot, with a ghosting guard band at the start of each slot.
- Optionally blanks leading zeros.
- Flags non-decimal nibbles and shows them as a dash.

Parameters:
- REFRESH_DIV, 27000, clock cycles per digit slot (1 ms at 27 MHz); legal range 4..2^20.
- GUARD, 16, cycles at the start of each slot with all digits off; must be < REFRESH_DIV.
- ACTIVE_LOW, 1, 1 = seg/dp/dig_en low-active; 0 = high-active.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- bcd_in  input  12  [3:0] ones, [7:4] tens, [11:8] hundreds
- load  input  1  one-cycle strobe; captures bcd_in
- blank_lz_en  input  1  1 = leading-zero blanking enabled (sampled live)
- seg  output  7  {g,f,e,d,c,b,a} segment drive
- dp  output  1  decimal point; always inactive
- dig_en  output  3  one-hot digit enable: [0] ones, [1] tens, [2] hundreds
- err  output  1  1 while the displayed value contains a nibble > 9
- frame  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- State:
  - prescaler cnt, 0..REFRESH_DIV-1
  - digit index idx, 0..2
  - pending register pend plus pend_v flag
  - display register disp
- Reset (rst_n low at a clk edge), all values are ACTIVE_LOW=1 encoding:
  - cnt=0, idx=0, pend=0, pend_v=0, disp=0
  - seg=7'h7F, dp=1, dig_en=3'b111 (all off), err=0, frame=0
  - Reset mid-scan aborts the slot immediately. A pending load is discarded.
- Prescaler:
  - cnt increments every cycle.
  - tick = (cnt==REFRESH_DIV-1); on tick, cnt wraps to 0 and idx advances 0→1→2→0.
  - frame asserts the cycle after idx goes 2→0.
- Load:
  - On load, pend<=bcd_in and pend_v<=1. A later load before application overwrites pend; last wins.
  - On a wrap tick (idx==2 and tick): disp<=pend if pend_v, then pend_v<=0. No tearing within a frame.
  - If load and the wrap tick coincide, bcd_in goes straight to disp and pend_v stays 0.
- Outputs are registered, with one-cycle latency from (cnt, idx, disp):
  - if cnt < GUARD: dig_en all off, seg all off.
  - else: dig_en = one-hot(idx), and seg = decode(nibble idx of disp) after blanking.
- Decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - 10..15 → dash 40
  - blank → 00
  - ACTIVE_LOW=1 inverts seg, dp and dig_en.
- Leading-zero blanking, when blank_lz_en=1:
  - hundreds is blank if its nibble is 0.
  - tens is blank if hundreds and tens are both 0.
  - ones is never blanked.
  - Invalid nibbles count as non-zero.
  - dig_en still pulses for blanked digits; seg is all off.
- err: registered; err = any nibble of disp > 9. It updates the cycle after disp changes.
- REFRESH_DIV and GUARD are static; no runtime change.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-slot → seg=7'h7F, dig_en=3'b111, err=0, frame=0; after release, cnt and idx restart at 0.
- Decode 123, with REFRESH_DIV=8, GUARD=2, blank_lz_en=0: load 12'h123, wait one frame → dig_en=110 with seg=7'h30, dig_en=101 with seg=7'h24, dig_en=011 with seg=7'h79. Each digit is active 6 of 8 cycles; the first 2 cycles of each slot are all off. frame pulses every 24 cycles.
- Leading zeros: load 12'h007, blank_lz_en=1 → ones seg=7'h78, tens and hundreds seg=7'h7F. With blank_lz_en=0 → tens/hundreds seg=7'h40. For 12'h070 with blanking → tens=7'h78, ones=7'h40.
- Invalid digit: load 12'h1A3 → tens seg=7'h3F (dash), err=1. Then load 12'h123 → err=0 the cycle after the next frame boundary.
- Load timing:
  - Load 12'h456 at idx=1 mid-slot → remaining digits of that frame still show the old value; the new value appears from the next frame.
  - Two loads in one frame → only the second is displayed.
  - Load on the wrap tick → the value appears in the immediately following frame.
- Reset mid-operation: assert rst_n=0 with pend_v=1 → after release, disp=0 and the pending value is never displayed.
